// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX path and the matching RX path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned DEFAULT_BIT_WIDTH    = 8;
  localparam int unsigned DEFAULT_FRAME_CYCLES = (DEFAULT_BIT_WIDTH + 2) * DEFAULT_CLKS_PER_BIT;

  // Clock cycles in one 8N1-style frame: start + data bits + stop.
  function automatic int unsigned frame_cycles(input int unsigned cpb, input int unsigned bw);
    return (bw + 2) * cpb;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the TX FIFO and its UART consumer.
interface fifo_uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
);

  logic                 fifo_can_read;
  logic [BIT_WIDTH-1:0] fifo_read_data;
  logic                 fifo_read;

  // Consumer side: observes head word, issues pops.
  modport master (
    input  fifo_can_read,
    input  fifo_read_data,
    output fifo_read
  );

  // FIFO side: presents head word, receives pops.
  modport slave (
    output fifo_can_read,
    output fifo_read_data,
    input  fifo_read
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter; bit_done marks the last cycle of each serial bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_done = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and sends each as a back-to-back UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned BIT_WIDTH    = DEFAULT_BIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  txd,
  output logic                  busy
);

  localparam int unsigned IDX_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_WIDTH - 1);

  uart_state_e          state_q, state_d;
  logic [BIT_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 txd_d, busy_d, read_d;
  logic                 load_c, timer_clear_c, bit_done;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear_c),
    .bit_done (bit_done)
  );

  assign load_c = fifo.fifo_can_read && enable;

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    txd_d         = txd;
    busy_d        = busy;
    read_d        = 1'b0;
    timer_clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clear_c = 1'b1;
        txd_d         = 1'b1;
        busy_d        = 1'b0;
        if (load_c) begin
          shift_d = fifo.fifo_read_data;
          read_d  = 1'b1;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            txd_d = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (load_c) begin
            shift_d       = fifo.fifo_read_data;
            read_d        = 1'b1;
            txd_d         = 1'b0;
            timer_clear_c = 1'b1;
            state_d       = START;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      idx_q          <= '0;
      txd            <= 1'b1;
      busy           <= 1'b0;
      fifo.fifo_read <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      idx_q          <= idx_d;
      txd            <= txd_d;
      busy           <= busy_d;
      fifo.fifo_read <= read_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with behavioural FIFO models.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable_a, enable_b;
  logic txd_a, busy_a, txd_b, busy_b;
  logic mask_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.BIT_WIDTH(8)) bus_a ();
  fifo_uart_tx_if #(.BIT_WIDTH(8)) bus_b ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB_A), .BIT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .fifo(bus_a), .txd(txd_a), .busy(busy_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB_B), .BIT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .fifo(bus_b), .txd(txd_b), .busy(busy_b)
  );

  // FIFO model A
  logic [7:0] mem_a [16];
  logic [4:0] wr_a = '0;
  logic [4:0] rd_a = '0;
  int         pops_a = 0;
  logic       under_a = 1'b0;
  assign bus_a.fifo_can_read  = (wr_a != rd_a);
  assign bus_a.fifo_read_data = mem_a[rd_a[3:0]];
  always @(posedge clk) begin
    if (bus_a.fifo_read) begin
      if (wr_a == rd_a) under_a <= 1'b1;
      rd_a   <= rd_a + 5'd1;
      pops_a <= pops_a + 1;
    end
  end

  // FIFO model B, with a mask to pulse can_read low
  logic [7:0] mem_b [16];
  logic [4:0] wr_b = '0;
  logic [4:0] rd_b = '0;
  int         pops_b = 0;
  logic       under_b = 1'b0;
  assign bus_b.fifo_can_read  = (wr_b != rd_b) && !mask_b;
  assign bus_b.fifo_read_data = mem_b[rd_b[3:0]];
  always @(posedge clk) begin
    if (bus_b.fifo_read) begin
      if (wr_b == rd_b) under_b <= 1'b1;
      rd_b   <= rd_b + 5'd1;
      pops_b <= pops_b + 1;
    end
  end

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a[3:0]] = b;
    wr_a = wr_a + 5'd1;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b[3:0]] = b;
    wr_b = wr_b + 5'd1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle capture, one sample per negedge
  logic [127:0] cap_tx, cap_fr;
  int           cap_busy, cap_idx;

  task automatic cap_clear();
    cap_tx = '0; cap_fr = '0; cap_busy = 0; cap_idx = 0;
  endtask

  task automatic capture(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[cap_idx] = sel_b ? txd_b : txd_a;
      cap_fr[cap_idx] = sel_b ? bus_b.fifo_read : bus_a.fifo_read;
      if ((sel_b ? busy_b : busy_a) === 1'b1) cap_busy++;
      cap_idx++;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] add_frame(input logic [127:0] acc, input logic [7:0] b,
                                             input int cpb, input int start);
    logic [9:0] fb;
    fb = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * cpb; i++) acc[start + i] = fb[i / cpb];
    return acc;
  endfunction

  logic [127:0] exp_tx, exp_fr;
  int           n_err;

  initial begin
    rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0; mask_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 128'(txd_a), 128'(1));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_read", 128'(bus_a.fifo_read), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Idle with empty FIFO and enable high
    enable_a = 1'b1;
    n_err = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_read !== 1'b0) n_err++;
      @(negedge clk);
    end
    check("idle50", 128'(n_err), 128'(0));
    check("idle_pops", 128'(pops_a), 128'(0));

    // Single frame 0xA5
    push_a(8'hA5);
    @(negedge clk);
    cap_clear();
    capture(1'b0, 40);
    exp_tx = add_frame('0, 8'hA5, CPB_A, 0);
    check("a5_txd", cap_tx, exp_tx);
    check("a5_read", cap_fr, 128'(1));
    check("a5_busy_cnt", 128'(cap_busy), 128'(40));
    check("a5_busy_end", 128'(busy_a), 128'(0));
    check("a5_txd_end", 128'(txd_a), 128'(1));
    check("a5_pops", 128'(pops_a), 128'(1));

    // Three queued bytes, released by enable
    enable_a = 1'b0;
    push_a(8'h00); push_a(8'hFF); push_a(8'h3C);
    repeat (5) @(negedge clk);
    check("hold_busy", 128'(busy_a), 128'(0));
    check("hold_pops", 128'(pops_a), 128'(1));
    enable_a = 1'b1;
    @(negedge clk);
    cap_clear();
    capture(1'b0, 120);
    exp_tx = add_frame('0, 8'h00, CPB_A, 0);
    exp_tx = add_frame(exp_tx, 8'hFF, CPB_A, 40);
    exp_tx = add_frame(exp_tx, 8'h3C, CPB_A, 80);
    exp_fr = '0;
    exp_fr[0] = 1'b1; exp_fr[40] = 1'b1; exp_fr[80] = 1'b1;
    check("b2b_txd", cap_tx, exp_tx);
    check("b2b_read", cap_fr, exp_fr);
    check("b2b_busy_cnt", 128'(cap_busy), 128'(120));
    check("b2b_busy_end", 128'(busy_a), 128'(0));
    check("b2b_pops", 128'(pops_a), 128'(4));
    check("b2b_level", 128'(wr_a - rd_a), 128'(0));

    // Enable dropped during data bits with two bytes queued
    push_a(8'h5A); push_a(8'hC3);
    @(negedge clk);
    cap_clear();
    capture(1'b0, 10);
    enable_a = 1'b0;
    capture(1'b0, 30);
    exp_tx = add_frame('0, 8'h5A, CPB_A, 0);
    check("drop_txd", cap_tx, exp_tx);
    check("drop_busy_cnt", 128'(cap_busy), 128'(40));
    check("drop_busy_end", 128'(busy_a), 128'(0));
    repeat (20) @(negedge clk);
    check("drop_pops", 128'(pops_a), 128'(5));
    check("drop_level", 128'(wr_a - rd_a), 128'(1));

    // Reset during data bit 3 of 0xC3
    enable_a = 1'b1;
    @(negedge clk);
    repeat (17) @(negedge clk);
    check("pre_rst_busy", 128'(busy_a), 128'(1));
    check("pre_rst_txd", 128'(txd_a), 128'(0));
    #1 rst = 1'b1;
    #1;
    check("async_txd", 128'(txd_a), 128'(1));
    check("async_busy", 128'(busy_a), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_err = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_read !== 1'b0) n_err++;
    end
    check("post_rst_idle", 128'(n_err), 128'(0));
    check("post_rst_pops", 128'(pops_a), 128'(6));

    // CLKS_PER_BIT=2 with can_read pulsed low mid-frame
    enable_b = 1'b1;
    push_b(8'h96);
    @(negedge clk);
    cap_clear();
    capture(1'b1, 3);
    mask_b = 1'b1;
    capture(1'b1, 1);
    mask_b = 1'b0;
    capture(1'b1, 16);
    exp_tx = add_frame('0, 8'h96, CPB_B, 0);
    check("c2_txd", cap_tx, exp_tx);
    check("c2_read", cap_fr, 128'(1));
    check("c2_busy_cnt", 128'(cap_busy), 128'(20));
    check("c2_busy_end", 128'(busy_b), 128'(0));
    repeat (10) @(negedge clk);
    check("c2_pops", 128'(pops_b), 128'(1));
    check("underflow", 128'({under_a, under_b}), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
